addr_fifo_reader: RTL and testbench
===================================

// Module: addr_fifo_reader
// PURPOSE
//  Read side of the address FIFO filled by the register slave (writes to 0x0000_0000).
//  Pops 32-bit address words, expands each into a burst of consecutive vector
//  addresses when consecutive mode is on, and presents them on a valid/ready port.
//  Also supplies addr_cycle_cnt and the addr_fifo_underrun flag back to the
//  control/status registers.
// PARAMETERS
//  ADDR_W       32  width of FIFO words and of vctr_addr
//  CONSEC_W      8  width of consec_count / burst remaining counter
//  CYCLE_CNT_W  16  width of addr_cycle_cnt
// PORTS
//  clk                 in   1            single clock for the whole block
//  reset               in   1            asynchronous, active-low reset
//  active_program      in   1            program running; rising edge starts, low aborts
//  freeze_addr_fifo    in   1            1 = no new FIFO pops
//  send_consec_addr    in   1            1 = expand each word into a burst
//  consec_count        in   CONSEC_W     extra addresses after the base (burst = N+1)
//  addr_fifo_dout      in   ADDR_W       FIFO head word (FWFT: valid while !empty)
//  addr_fifo_empty     in   1            FIFO empty
//  addr_fifo_rd        out  1            one-cycle pop strobe
//  vctr_addr           out  ADDR_W       vector address
//  vctr_addr_valid     out  1            vctr_addr valid
//  vctr_addr_ready     in   1            downstream accepts when valid&ready
//  addr_cycle_cnt      out  CYCLE_CNT_W  addresses accepted this program, saturating
//  addr_fifo_underrun  out  1            sticky: FIFO ran dry mid-program
//  busy                out  1            state != IDLE
// BEHAVIOUR
//  - Reset (async, reset=0): all outputs 0, state IDLE, remaining=0.
//  - States: IDLE, FETCH, EMIT.
//  - IDLE: on active_program 0->1 (registered edge detect): clear addr_cycle_cnt
//    and addr_fifo_underrun, go FETCH.
//  - FETCH:
//    - active_program=0 -> IDLE.
//    - freeze_addr_fifo=1 -> stay; no pop.
//    - !addr_fifo_empty -> at the next edge: vctr_addr<=dout,
//      vctr_addr_valid<=1, addr_fifo_rd<=1 for exactly one cycle,
//      remaining<=send_consec_addr ? consec_count : 0, go EMIT.
//      send_consec_addr and consec_count are sampled here only.
//    - empty and addr_cycle_cnt!=0 -> addr_fifo_underrun<=1 (sticky until the next
//      program start); stay FETCH. Empty before the first address is not underrun.
//  - EMIT: valid held, vctr_addr stable, until vctr_addr_ready=1.
//    - On handshake: addr_cycle_cnt+1 (saturates at all-ones).
//      - remaining==0 -> valid<=0, go FETCH.
//      - else vctr_addr<=vctr_addr+1 (wraps modulo 2^ADDR_W), remaining-1, valid stays 1.
//    - freeze_addr_fifo has no effect inside EMIT; the burst in flight completes.
//  - Throughput: burst addresses back-to-back. One bubble cycle between FIFO words
//    (EMIT->FETCH). Latency from FIFO non-empty in FETCH to valid: 1 clk.
//  - active_program=0 in any non-IDLE state: valid<=0 next edge, go IDLE. The popped
//    word and the rest of the burst are discarded. addr_cycle_cnt and underrun hold.
//  - Simultaneous abort and handshake: the handshake counts, then abort.
//  - Reset mid-burst: immediate return to reset values.
// TESTING
//  1 FIFO={0x100}, consec off, ready=1 -> one pop, vctr_addr=0x100 for 1 clk, cnt=1.
//  2 FIFO={0x200}, consec on, count=3, ready=1 -> 0x200..0x203 on 4 consecutive clks, cnt=4.
//  3 FIFO={0xFFFF_FFFE}, count=2 -> 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
//  4 Ready low 5 clks during burst -> vctr_addr/valid stable, no extra pop, cnt unchanged.
//  5 Two words emitted, FIFO empty, active -> underrun=1. New program start -> underrun=0, cnt=0.
//  6 active_program drops mid-burst -> valid=0 next clk, state IDLE, no further pops.
//    Also: freeze=1 in FETCH with FIFO non-empty -> no pop until freeze=0.

Source files
------------

// File: rtl/addr_fifo_reader.sv
// addr_fifo_reader: pops address words from a FWFT FIFO and expands each one
// into a burst of consecutive vector addresses on a valid/ready port.
//   clk, reset (async, active-low)
//   active_program     : rising edge starts a program, low aborts it
//   freeze_addr_fifo   : blocks new FIFO pops (a burst in flight completes)
//   send_consec_addr   : expand each word into consec_count+1 addresses
//   consec_count       : extra addresses after the base word
//   addr_fifo_dout/empty, addr_fifo_rd : FIFO head, empty flag, pop strobe
//   vctr_addr/valid/ready              : address output handshake
//   addr_cycle_cnt     : saturating count of accepted addresses this program
//   addr_fifo_underrun : sticky, FIFO ran dry after the first address
//   busy               : not idle
module addr_fifo_reader #(
    parameter int ADDR_W      = 32,
    parameter int CONSEC_W    = 8,
    parameter int CYCLE_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   active_program,
    input  logic                   freeze_addr_fifo,
    input  logic                   send_consec_addr,
    input  logic [CONSEC_W-1:0]    consec_count,
    input  logic [ADDR_W-1:0]      addr_fifo_dout,
    input  logic                   addr_fifo_empty,
    output logic                   addr_fifo_rd,
    output logic [ADDR_W-1:0]      vctr_addr,
    output logic                   vctr_addr_valid,
    input  logic                   vctr_addr_ready,
    output logic [CYCLE_CNT_W-1:0] addr_cycle_cnt,
    output logic                   addr_fifo_underrun,
    output logic                   busy
);
    typedef enum logic [1:0] {IDLE, FETCH, EMIT} state_t;
    state_t                 state, state_n;
    logic                   act_q;
    logic [CONSEC_W-1:0]    remaining, remaining_n;
    logic [ADDR_W-1:0]      addr_n;
    logic                   valid_n, rd_n, underrun_n;
    logic [CYCLE_CNT_W-1:0] cnt_n;
    assign busy = state != IDLE;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state              <= IDLE;
            act_q              <= 1'b0;
            remaining          <= '0;
            vctr_addr          <= '0;
            vctr_addr_valid    <= 1'b0;
            addr_fifo_rd       <= 1'b0;
            addr_cycle_cnt     <= '0;
            addr_fifo_underrun <= 1'b0;
        end else begin
            state              <= state_n;
            act_q              <= active_program;
            remaining          <= remaining_n;
            vctr_addr          <= addr_n;
            vctr_addr_valid    <= valid_n;
            addr_fifo_rd       <= rd_n;
            addr_cycle_cnt     <= cnt_n;
            addr_fifo_underrun <= underrun_n;
        end
    end
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        addr_n      = vctr_addr;
        valid_n     = vctr_addr_valid;
        rd_n        = 1'b0;
        cnt_n       = addr_cycle_cnt;
        underrun_n  = addr_fifo_underrun;
        case (state)
            IDLE: begin
                if (active_program && !act_q) begin
                    cnt_n      = '0;
                    underrun_n = 1'b0;
                    state_n    = FETCH;
                end
            end
            FETCH: begin
                if (!active_program) begin
                    state_n = IDLE;
                end else if (!freeze_addr_fifo) begin
                    if (!addr_fifo_empty) begin
                        addr_n      = addr_fifo_dout;
                        valid_n     = 1'b1;
                        rd_n        = 1'b1;
                        remaining_n = send_consec_addr ? consec_count : '0;
                        state_n     = EMIT;
                    end else if (addr_cycle_cnt != '0) begin
                        // empty before the first address of a program is not an underrun
                        underrun_n = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (vctr_addr_valid && vctr_addr_ready) begin
                    cnt_n = (&addr_cycle_cnt) ? addr_cycle_cnt : addr_cycle_cnt + 1'b1;
                    if (remaining == '0) begin
                        valid_n = 1'b0;
                        state_n = FETCH;
                    end else begin
                        addr_n      = vctr_addr + 1'b1;
                        remaining_n = remaining - 1'b1;
                    end
                end
                // abort wins over the burst but a same-cycle handshake still counts
                if (!active_program) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_addr_fifo_reader.sv
// tb_addr_fifo_reader: table-driven bursts plus hand sequences, scoreboarded addresses
module tb_addr_fifo_reader;
    logic        clk = 1'b0;
    logic        reset;
    logic        active_program;
    logic        freeze_addr_fifo;
    logic        send_consec_addr;
    logic [7:0]  consec_count;
    logic [31:0] addr_fifo_dout;
    logic        addr_fifo_empty;
    logic        addr_fifo_rd;
    logic [31:0] vctr_addr;
    logic        vctr_addr_valid;
    logic        vctr_addr_ready;
    logic [15:0] addr_cycle_cnt;
    logic        addr_fifo_underrun;
    logic        busy;

    addr_fifo_reader dut (
        .clk(clk), .reset(reset), .active_program(active_program),
        .freeze_addr_fifo(freeze_addr_fifo), .send_consec_addr(send_consec_addr),
        .consec_count(consec_count), .addr_fifo_dout(addr_fifo_dout),
        .addr_fifo_empty(addr_fifo_empty), .addr_fifo_rd(addr_fifo_rd),
        .vctr_addr(vctr_addr), .vctr_addr_valid(vctr_addr_valid),
        .vctr_addr_ready(vctr_addr_ready), .addr_cycle_cnt(addr_cycle_cnt),
        .addr_fifo_underrun(addr_fifo_underrun), .busy(busy)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model: mem/wp written by the stimulus, rp advanced by pops
    logic [31:0] mem [64];
    logic [5:0]  wp = '0;
    logic [5:0]  rp = '0;
    int          pops = 0;
    assign addr_fifo_dout  = mem[rp];
    assign addr_fifo_empty = (rp == wp);
    always @(posedge clk)
        if (addr_fifo_rd && rp != wp) begin
            rp   <= rp + 1'b1;
            pops <= pops + 1;
        end

    typedef struct {
        logic [31:0] base;
        logic        consec;
        logic [7:0]  cnt;
        bit          rnd;
        int          exp_cnt;
    } row_t;
    row_t rows[6];

    logic [31:0] sb[$];
    bit          sb_on = 1'b1;
    int          n_cmp = 0, n_fail = 0;
    int          hs = 0, v_cycles = 0, p0 = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (vctr_addr_valid) v_cycles++;
        if (vctr_addr_valid && vctr_addr_ready) begin
            hs++;
            if (sb_on) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got %0h want none", vctr_addr);
                end else chk("sb_addr", 64'(vctr_addr), 64'(sb.pop_front()));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        mem[wp] = w;
        wp = wp + 1'b1;
    endtask

    task automatic start_prog();
        active_program = 1'b0;
        tick();
        tick();
        active_program = 1'b1;
        tick();
    endtask

    task automatic drain(input bit rnd);
        for (int t = 0; t < 400 && sb.size() != 0; t++) begin
            if (rnd) vctr_addr_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        vctr_addr_ready = 1'b1;
        if (sb.size() != 0) chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        rows[0] = '{32'h0000_0100, 1'b0, 8'd0,  1'b0, 1};
        rows[1] = '{32'h0000_0200, 1'b1, 8'd3,  1'b0, 4};
        rows[2] = '{32'hFFFF_FFFE, 1'b1, 8'd2,  1'b0, 3};
        rows[3] = '{32'h0000_1000, 1'b0, 8'd5,  1'b1, 1};
        rows[4] = '{32'hABCD_0000, 1'b1, 8'd0,  1'b1, 1};
        rows[5] = '{32'h0000_07FF, 1'b1, 8'd10, 1'b1, 11};

        reset = 1'b0;
        active_program = 1'b0;
        freeze_addr_fifo = 1'b0;
        send_consec_addr = 1'b0;
        consec_count = '0;
        vctr_addr_ready = 1'b1;
        #3;
        chk("rst_valid", 64'(vctr_addr_valid), 64'd0);
        chk("rst_addr", 64'(vctr_addr), 64'd0);
        chk("rst_rd", 64'(addr_fifo_rd), 64'd0);
        chk("rst_cnt", 64'(addr_cycle_cnt), 64'd0);
        chk("rst_underrun", 64'(addr_fifo_underrun), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            send_consec_addr = rows[i].consec;
            consec_count = rows[i].cnt;
            vctr_addr_ready = 1'b1;
            start_prog();
            p0 = pops;
            v_cycles = 0;
            push(rows[i].base);
            for (int k = 0; k <= (rows[i].consec ? int'(rows[i].cnt) : 0); k++)
                sb.push_back(rows[i].base + 32'(k));
            drain(rows[i].rnd);
            tick();
            tick();
            chk("row_cnt", 64'(addr_cycle_cnt), 64'(rows[i].exp_cnt));
            chk("row_pops", 64'(pops - p0), 64'd1);
            chk("row_underrun", 64'(addr_fifo_underrun), 64'd1);
            chk("row_busy", 64'(busy), 64'd1);
            if (!rows[i].rnd) chk("row_back_to_back", 64'(v_cycles), 64'(rows[i].exp_cnt));
        end

        // ready held low mid-burst, freeze raised inside the burst
        send_consec_addr = 1'b1;
        consec_count = 8'd3;
        vctr_addr_ready = 1'b0;
        start_prog();
        p0 = pops;
        push(32'h300);
        for (int k = 0; k < 4; k++) sb.push_back(32'h300 + 32'(k));
        tick();
        chk("stall_valid", 64'(vctr_addr_valid), 64'd1);
        freeze_addr_fifo = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_addr", 64'(vctr_addr), 64'h300);
            chk("stall_cnt", 64'(addr_cycle_cnt), 64'd0);
        end
        chk("stall_pops", 64'(pops - p0), 64'd1);
        vctr_addr_ready = 1'b1;
        drain(1'b0);
        freeze_addr_fifo = 1'b0;
        tick();
        chk("stall_cnt_end", 64'(addr_cycle_cnt), 64'd4);
        chk("stall_pops_end", 64'(pops - p0), 64'd1);

        // underrun only after first address; cleared by a new program
        send_consec_addr = 1'b0;
        start_prog();
        chk("start_cnt", 64'(addr_cycle_cnt), 64'd0);
        chk("start_underrun", 64'(addr_fifo_underrun), 64'd0);
        tick();
        tick();
        tick();
        chk("early_empty", 64'(addr_fifo_underrun), 64'd0);
        push(32'h10);
        sb.push_back(32'h10);
        tick();
        chk("latency_valid", 64'(vctr_addr_valid), 64'd1);
        chk("latency_addr", 64'(vctr_addr), 64'h10);
        push(32'h20);
        sb.push_back(32'h20);
        drain(1'b0);
        tick();
        tick();
        chk("underrun_set", 64'(addr_fifo_underrun), 64'd1);
        chk("underrun_cnt", 64'(addr_cycle_cnt), 64'd2);
        start_prog();
        chk("restart_underrun", 64'(addr_fifo_underrun), 64'd0);
        chk("restart_cnt", 64'(addr_cycle_cnt), 64'd0);

        // abort mid-burst with a handshake on the abort cycle
        send_consec_addr = 1'b1;
        consec_count = 8'd7;
        sb_on = 1'b0;
        start_prog();
        hs = 0;
        p0 = pops;
        push(32'h500);
        push(32'h600);
        tick();
        tick();
        tick();
        active_program = 1'b0;
        tick();
        chk("abort_valid", 64'(vctr_addr_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_hs", 64'(hs), 64'd3);
        chk("abort_cnt", 64'(addr_cycle_cnt), 64'(hs));
        tick();
        tick();
        tick();
        chk("abort_pops", 64'(pops - p0), 64'd1);
        chk("abort_fifo_kept", 64'(addr_fifo_empty), 64'd0);
        chk("abort_cnt_hold", 64'(addr_cycle_cnt), 64'd3);

        // freeze in FETCH with a word waiting
        send_consec_addr = 1'b0;
        freeze_addr_fifo = 1'b1;
        sb_on = 1'b1;
        start_prog();
        p0 = pops;
        for (int k = 0; k < 4; k++) tick();
        chk("freeze_pops", 64'(pops - p0), 64'd0);
        chk("freeze_valid", 64'(vctr_addr_valid), 64'd0);
        chk("freeze_busy", 64'(busy), 64'd1);
        sb.push_back(32'h600);
        freeze_addr_fifo = 1'b0;
        tick();
        chk("unfreeze_addr", 64'(vctr_addr), 64'h600);
        drain(1'b0);
        tick();
        chk("unfreeze_cnt", 64'(addr_cycle_cnt), 64'd1);

        // asynchronous reset mid-burst
        consec_count = 8'd5;
        send_consec_addr = 1'b1;
        vctr_addr_ready = 1'b0;
        sb_on = 1'b0;
        start_prog();
        push(32'h900);
        tick();
        chk("pre_reset_valid", 64'(vctr_addr_valid), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_valid", 64'(vctr_addr_valid), 64'd0);
        chk("async_rst_addr", 64'(vctr_addr), 64'd0);
        chk("async_rst_cnt", 64'(addr_cycle_cnt), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_rd", 64'(addr_fifo_rd), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
